// File: rtl/rx_framer_pkg.sv
// Shared Ethernet receive/transmit definitions: framing bytes, CRC-32
// constants, framer state encoding and the byte-wide CRC step helper.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   localparam int unsigned LEN_W         = 11;
   localparam logic [10:0] LEN_SAT       = 11'd2047;

   localparam int unsigned PRE_CNT_W     = 3;
   localparam logic [2:0]  PRE_CNT_SAT   = 3'd7;

   // One-hot framer states
   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0001,
      ST_PREAMBLE = 4'b0010,
      ST_BODY     = 4'b0100,
      ST_DROP     = 4'b1000
   } rx_state_e;

   // One byte of reflected CRC-32, data consumed LSB first
   function automatic logic [31:0] crc32_step(input logic [31:0] crc_in,
                                              input logic [7:0]  byte_in);
      logic [31:0] c;
      c = crc_in ^ {24'h000000, byte_in};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/rx_framer_if.sv
// PHY receive inputs, downstream byte stream and frame status of the
// receive framer, bundled as one interface.
interface rx_framer_if;

   logic       phy_dv;
   logic       phy_err;
   logic [7:0] phy_data;

   logic       rx_enable;
   logic [7:0] data;
   logic       frame_done;
   logic       crc_ok;
   logic       frame_err;

   // Framer side: consumes the PHY stream, produces the frame stream
   modport master (
      input  phy_dv, phy_err, phy_data,
      output rx_enable, data, frame_done, crc_ok, frame_err
   );

   // Environment side: PHY source plus downstream consumer
   modport slave (
      output phy_dv, phy_err, phy_data,
      input  rx_enable, data, frame_done, crc_ok, frame_err
   );

endinterface

// File: rtl/crc32_byte.sv
// Byte-serial CRC-32 accumulator, shared by the receive and transmit paths.
// clear reloads the initial value and takes priority over a data step.
module crc32_byte
   import eth_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  data_in,
   output logic [31:0] crc
);

   logic [31:0] crc_r;

   // CRC register: reload on clear, advance one byte per enabled cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_r <= CRC_INIT;
      end else if (clear) begin
         crc_r <= CRC_INIT;
      end else if (enable) begin
         crc_r <= crc32_step(crc_r, data_in);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/rx_framer.sv
// GMII receive framer: strips preamble/SFD, forwards body bytes one cycle
// late, checks the FCS residue and reports frame status at frame end.
// Bad preambles are dropped silently; overlong frames are cut at MAX_LEN.
module rx_framer
   import eth_pkg::*;
#(
   parameter int unsigned MIN_PREAMBLE = 2,
   parameter int unsigned MAX_LEN      = 1522,
   parameter int unsigned MIN_LEN      = 64
)
(
   input  logic         clock,
   input  logic         reset_n,
   rx_framer_if.master  bus
);

   localparam logic [PRE_CNT_W-1:0] MIN_PRE_C = PRE_CNT_W'(MIN_PREAMBLE);
   localparam logic [LEN_W-1:0]     MAX_LEN_C = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]     MIN_LEN_C = LEN_W'(MIN_LEN);

   rx_state_e            state_r,   state_s;
   logic [PRE_CNT_W-1:0] pre_cnt_r, pre_cnt_s;
   logic [LEN_W-1:0]     len_r,     len_s;
   logic                 err_r,     err_s;

   logic                 rx_enable_r,  rx_enable_s;
   logic [7:0]           data_r,       data_s;
   logic                 frame_done_r, frame_done_s;
   logic                 crc_ok_r,     crc_ok_s;
   logic                 frame_err_r,  frame_err_s;

   logic                 crc_clear_s;
   logic                 crc_enable_s;
   logic [31:0]          crc_s;

   crc32_byte u_crc (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (crc_clear_s),
      .enable  (crc_enable_s),
      .data_in (bus.phy_data),
      .crc     (crc_s)
   );

   // Next-state, counters and next output values of the framer
   always_comb begin
      state_s      = state_r;
      pre_cnt_s    = pre_cnt_r;
      len_s        = len_r;
      err_s        = err_r;
      rx_enable_s  = 1'b0;
      data_s       = data_r;
      frame_done_s = 1'b0;
      crc_ok_s     = crc_ok_r;
      frame_err_s  = frame_err_r;
      crc_clear_s  = 1'b0;
      crc_enable_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (bus.phy_dv) begin
               if (bus.phy_data == PREAMBLE_BYTE) begin
                  pre_cnt_s = 3'd1;
                  state_s   = ST_PREAMBLE;
               end else begin
                  state_s   = ST_DROP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_PREAMBLE: begin
            if (!bus.phy_dv) begin
               // Carrier lost before the SFD: nothing was delivered
               state_s = ST_IDLE;
            end else if (bus.phy_data == PREAMBLE_BYTE) begin
               if (pre_cnt_r != PRE_CNT_SAT) begin
                  pre_cnt_s = pre_cnt_r + 3'd1;
               end else begin
                  pre_cnt_s = pre_cnt_r;
               end
            end else if ((bus.phy_data == SFD_BYTE) && (pre_cnt_r >= MIN_PRE_C)) begin
               crc_clear_s = 1'b1;
               len_s       = 11'd0;
               err_s       = 1'b0;
               state_s     = ST_BODY;
            end else begin
               state_s = ST_DROP;
            end
         end

         ST_BODY: begin
            if (!bus.phy_dv) begin
               // Normal end: the CRC register already holds every body byte
               frame_done_s = 1'b1;
               crc_ok_s     = (crc_s == CRC_RESIDUE);
               frame_err_s  = err_r | (len_r < MIN_LEN_C) | (len_r > MAX_LEN_C);
               state_s      = ST_IDLE;
            end else if (len_r >= MAX_LEN_C) begin
               // One byte too many: cut the frame, discard the rest
               frame_done_s = 1'b1;
               crc_ok_s     = 1'b0;
               frame_err_s  = 1'b1;
               state_s      = ST_DROP;
            end else begin
               rx_enable_s  = 1'b1;
               data_s       = bus.phy_data;
               crc_enable_s = 1'b1;
               err_s        = err_r | bus.phy_err;
               if (len_r != LEN_SAT) begin
                  len_s = len_r + 11'd1;
               end else begin
                  len_s = len_r;
               end
            end
         end

         ST_DROP: begin
            if (!bus.phy_dv) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DROP;
            end
         end

         default: begin
            state_s = ST_DROP;
         end
      endcase
   end

   // Framer state, counters and registered outputs; reset lands in DROP
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_DROP;
         pre_cnt_r    <= 3'd0;
         len_r        <= 11'd0;
         err_r        <= 1'b0;
         rx_enable_r  <= 1'b0;
         data_r       <= 8'h00;
         frame_done_r <= 1'b0;
         crc_ok_r     <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         pre_cnt_r    <= pre_cnt_s;
         len_r        <= len_s;
         err_r        <= err_s;
         rx_enable_r  <= rx_enable_s;
         data_r       <= data_s;
         frame_done_r <= frame_done_s;
         crc_ok_r     <= crc_ok_s;
         frame_err_r  <= frame_err_s;
      end
   end

   assign bus.rx_enable  = rx_enable_r;
   assign bus.data       = data_r;
   assign bus.frame_done = frame_done_r;
   assign bus.crc_ok     = crc_ok_r;
   assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_rx_framer.sv
// Bench for rx_framer: hand sequences for timing corners, a table of
// directed frames and randomized frames judged by a frame-level model.
module tb_rx_framer;

   localparam int MIN_PRE = 2;
   localparam int MAXL    = 1522;
   localparam int MINL    = 64;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   rx_framer_if bus_if();

   rx_framer #(.MIN_PREAMBLE(MIN_PRE), .MAX_LEN(MAXL), .MIN_LEN(MINL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #4 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int   n;
      logic crc_ok;
      logic frame_err;
   } done_t;

   typedef struct {
      int npre;
      int bad_pos;
      int len;
      bit fcs_ok;
      int flip_at;
      int err_at;
      bit exp_done;
      bit exp_crc;
      bit exp_err;
      int exp_n;
   } vec_t;

   logic [7:0] body[$];
   logic [7:0] got[$];
   done_t      done_q[$];
   vec_t       tbl[12];

   // Monitor: collect delivered bytes and frame status pulses
   always @(negedge clock) begin
      done_t d;
      if (bus_if.rx_enable) got.push_back(bus_if.data);
      if (bus_if.frame_done) begin
         d.n         = got.size();
         d.crc_ok    = bus_if.crc_ok;
         d.frame_err = bus_if.frame_err;
         done_q.push_back(d);
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      bus_if.phy_dv   = dv;
      bus_if.phy_err  = er;
      bus_if.phy_data = d;
      @(posedge clock);
      #1;
   endtask

   // CRC-32 (IEEE, reflected) of body[0 .. n-1]
   function automatic logic [31:0] crc_range(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h000000, body[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic bit fcs_matches();
      int          n;
      logic [31:0] f;
      n = body.size();
      if (n < 4) return 1'b0;
      f = ~crc_range(n - 4);
      return f == {body[n-1], body[n-2], body[n-3], body[n-4]};
   endfunction

   task automatic build_body(input int len, input bit fcs_ok, input int flip_at);
      logic [31:0] f;
      body.delete();
      for (int i = 0; i < len; i++) body.push_back(8'($urandom));
      if (fcs_ok && len >= 4) begin
         f = ~crc_range(len - 4);
         for (int k = 0; k < 4; k++) body[len-4+k] = f[8*k +: 8];
      end
      if (flip_at >= 0 && flip_at < len) body[flip_at] = body[flip_at] ^ 8'h01;
   endtask

   task automatic send_frame(input int npre, input int bad_pos, input logic [7:0] bad_val,
                             input bit pre_err, input int err_at);
      for (int i = 0; i < npre; i++)
         drive(1'b1, pre_err ? 1'($urandom) : 1'b0, (i == bad_pos) ? bad_val : 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < body.size(); i++) drive(1'b1, (i == err_at), body[i]);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_frame(input int id, input bit exp_done, input bit exp_crc,
                              input bit exp_err, input int exp_n);
      int    waited;
      int    bad;
      done_t d;
      string tag;
      waited = 0;
      bad    = 0;
      tag    = $sformatf("frame%0d", id);
      if (exp_done) begin
         while (done_q.size() == 0 && waited < 16) begin
            @(negedge clock);
            waited++;
         end
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL %s_done: got no frame_done expected one", tag);
         end else begin
            #1;
            d = done_q.pop_front();
            chk({tag, "_nbytes"}, d.n, exp_n);
            chk({tag, "_crc_ok"}, d.crc_ok, exp_crc);
            chk({tag, "_frame_err"}, d.frame_err, exp_err);
            chk({tag, "_extra_done"}, done_q.size(), 0);
            for (int i = 0; i < got.size() && i < exp_n; i++)
               if (got[i] !== body[i]) bad++;
            chk({tag, "_data_mismatches"}, bad, 0);
         end
      end else begin
         repeat (4) @(negedge clock);
         #1;
         chk({tag, "_no_done"}, done_q.size(), 0);
         chk({tag, "_no_bytes"}, got.size(), 0);
      end
      got.delete();
      done_q.delete();
   endtask

   initial begin
      int          npre, bad_pos, len, flip_at, err_at, gap;
      bit          fcs_ok, acc, e_crc, e_err;
      logic [7:0]  bad_val;
      int          e_n;
      done_t       d0, d1;

      bus_if.phy_dv   = 1'b0;
      bus_if.phy_err  = 1'b0;
      bus_if.phy_data = 8'h00;

      // ---- reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset_rx_enable", bus_if.rx_enable, 1'b0);
      chk("reset_data", bus_if.data, 8'h00);
      chk("reset_frame_done", bus_if.frame_done, 1'b0);
      chk("reset_crc_ok", bus_if.crc_ok, 1'b0);
      chk("reset_frame_err", bus_if.frame_err, 1'b0);
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);

      // ---- cycle-exact good frame
      build_body(64, 1'b1, -1);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      chk("lat_sfd_no_enable", bus_if.rx_enable, 1'b0);
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 1'b0, body[i]);
         if (i == 0 || i == 63) begin
            chk($sformatf("lat_enable_b%0d", i), bus_if.rx_enable, 1'b1);
            chk($sformatf("lat_data_b%0d", i), bus_if.data, body[i]);
            chk($sformatf("lat_no_done_b%0d", i), bus_if.frame_done, 1'b0);
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("end_enable_low", bus_if.rx_enable, 1'b0);
      chk("end_frame_done", bus_if.frame_done, 1'b1);
      chk("end_crc_ok", bus_if.crc_ok, 1'b1);
      chk("end_frame_err", bus_if.frame_err, 1'b0);
      drive(1'b0, 1'b0, 8'h00);
      chk("end_done_one_cycle", bus_if.frame_done, 1'b0);
      chk("end_crc_ok_held", bus_if.crc_ok, 1'b1);
      check_frame(0, 1'b1, 1'b1, 1'b0, 64);

      // ---- directed table
      tbl[0]  = '{7, -1,   64, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0,   64};
      tbl[1]  = '{7, -1,   64, 1'b1, 10, -1, 1'b1, 1'b0, 1'b0,   64};
      tbl[2]  = '{7,  1,   64, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0,    0};
      tbl[3]  = '{1, -1,   64, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0,    0};
      tbl[4]  = '{7, -1, 1600, 1'b0, -1, -1, 1'b1, 1'b0, 1'b1, 1522};
      tbl[5]  = '{2, -1,   64, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0,   64};
      tbl[6]  = '{7, -1,   40, 1'b1, -1, -1, 1'b1, 1'b1, 1'b1,   40};
      tbl[7]  = '{7, -1,   64, 1'b1, -1, 20, 1'b1, 1'b1, 1'b1,   64};
      tbl[8]  = '{7, -1, 1522, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0, 1522};
      tbl[9]  = '{7, -1, 1523, 1'b1, -1, -1, 1'b1, 1'b0, 1'b1, 1522};
      tbl[10] = '{7, -1,   63, 1'b1, -1, -1, 1'b1, 1'b1, 1'b1,   63};
      tbl[11] = '{0, -1,   64, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0,    0};
      for (int t = 0; t < 12; t++) begin
         build_body(tbl[t].len, tbl[t].fcs_ok, tbl[t].flip_at);
         send_frame(tbl[t].npre, tbl[t].bad_pos, 8'h5A, 1'b0, tbl[t].err_at);
         check_frame(100 + t, tbl[t].exp_done, tbl[t].exp_crc, tbl[t].exp_err, tbl[t].exp_n);
      end

      // ---- back-to-back frames separated by a single idle cycle
      build_body(64, 1'b1, -1);
      send_frame(7, -1, 8'h00, 1'b0, -1);
      build_body(70, 1'b1, -1);
      send_frame(7, -1, 8'h00, 1'b0, -1);
      repeat (4) @(negedge clock);
      #1;
      chk("b2b_done_count", done_q.size(), 2);
      if (done_q.size() == 2) begin
         d0 = done_q[0];
         d1 = done_q[1];
         chk("b2b_first_nbytes", d0.n, 64);
         chk("b2b_first_crc_ok", d0.crc_ok, 1'b1);
         chk("b2b_second_nbytes", d1.n, 134);
         chk("b2b_second_crc_ok", d1.crc_ok, 1'b1);
         chk("b2b_second_frame_err", d1.frame_err, 1'b0);
      end
      got.delete();
      done_q.delete();

      // ---- reset in the middle of a body, released while phy_dv is high
      build_body(64, 1'b1, -1);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, body[i]);
      chk("rst_mid_enable_before", bus_if.rx_enable, 1'b1);
      chk("rst_mid_no_done_before", done_q.size(), 0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_rx_enable", bus_if.rx_enable, 1'b0);
      chk("rst_mid_data", bus_if.data, 8'h00);
      chk("rst_mid_frame_done", bus_if.frame_done, 1'b0);
      chk("rst_mid_crc_ok", bus_if.crc_ok, 1'b0);
      chk("rst_mid_frame_err", bus_if.frame_err, 1'b0);
      got.delete();
      done_q.delete();
      for (int i = 30; i < 34; i++) drive(1'b1, 1'b0, body[i]);
      reset_n = 1'b1;
      for (int i = 34; i < 64; i++) drive(1'b1, 1'b0, body[i]);
      drive(1'b0, 1'b0, 8'h00);
      check_frame(300, 1'b0, 1'b0, 1'b0, 0);
      build_body(64, 1'b1, -1);
      send_frame(7, -1, 8'h00, 1'b0, -1);
      check_frame(301, 1'b1, 1'b1, 1'b0, 64);

      // ---- randomized frames against the frame-level model
      for (int f = 0; f < 40; f++) begin
         npre    = $urandom_range(0, 8);
         bad_pos = -1;
         if (npre > 0 && $urandom_range(0, 5) == 0) bad_pos = $urandom_range(0, npre - 1);
         bad_val = 8'($urandom);
         if (bad_val == 8'h55 || bad_val == 8'hD5) bad_val = 8'h00;
         if ($urandom_range(0, 9) == 0) len = $urandom_range(1515, 1530);
         else                           len = $urandom_range(20, 140);
         fcs_ok  = ($urandom_range(0, 3) != 0);
         flip_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
         err_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
         gap     = $urandom_range(0, 2);

         build_body(len, fcs_ok, flip_at);
         send_frame(npre, bad_pos, bad_val, 1'b1, err_at);
         repeat (gap) drive(1'b0, 1'b0, 8'h00);

         // A preamble is accepted only if it is all 0x55, long enough, then SFD
         acc   = (npre >= MIN_PRE) && (bad_pos < 0);
         e_n   = (len > MAXL) ? MAXL : len;
         e_crc = (len <= MAXL) && fcs_matches();
         e_err = (len > MAXL) || (len < MINL) || (err_at >= 0);
         if (acc) check_frame(400 + f, 1'b1, e_crc, e_err, e_n);
         else     check_frame(400 + f, 1'b0, 1'b0, 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
